instruction_fetch_unit: RTL and testbench

//  Upstream stage of instruction_decoder: owns program_counter and instruction_register.
//  On a fetch request it reads one 16-bit word from program memory (req/ack handshake), latches it into

---
 rtl/instruction_fetch_unit.sv | 138 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns PC and IR, fetches one word per request over a req/ack memory port.
// Optional FETCH_TIMEOUT_EN adds a REQ-state watchdog that abandons a stalled fetch and pulses fetch_fault.
module instruction_fetch_unit #(
    parameter int              ADDR_WIDTH     = 8,
    parameter int              DATA_WIDTH     = 16,
    parameter logic [7:0]      RESET_PC       = 8'h00,
    parameter logic [15:0]     IR_IDLE_WORD   = 16'hFF00,
    parameter int              TIMEOUT_CYCLES = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fetch_start,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_value,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [DATA_WIDTH-1:0] instruction_register,
    output logic [ADDR_WIDTH-1:0] program_counter,
    output logic                  ir_valid,
    output logic                  busy,
    output logic                  fetch_fault
);

    // state | meaning
    // IDLE  | no fetch in flight; accepts fetch_start and direct pc_load
    // REQ   | mem_req held with stable mem_addr, waiting for mem_ack
    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PC_INIT = ADDR_WIDTH'(RESET_PC);
    localparam logic [DATA_WIDTH-1:0] IR_INIT = DATA_WIDTH'(IR_IDLE_WORD);

    state_t                  state;
    logic                    pend_valid;
    logic [ADDR_WIDTH-1:0]   pend_target;
    logic                    jump_sel;
    logic [ADDR_WIDTH-1:0]   jump_addr;
    logic [ADDR_WIDTH-1:0]   idle_fetch_addr;

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LOAD = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] tmo_count;
`endif

    // A jump presented on the completing cycle beats an older pending one.
    always_comb begin
        jump_sel        = pc_load | pend_valid;
        jump_addr       = pc_load ? pc_load_value : pend_target;
        idle_fetch_addr = pc_load ? pc_load_value : program_counter;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state                <= IDLE;
            program_counter      <= PC_INIT;
            instruction_register <= IR_INIT;
            mem_req              <= 1'b0;
            mem_addr             <= '0;
            ir_valid             <= 1'b0;
            busy                 <= 1'b0;
            fetch_fault          <= 1'b0;
            pend_valid           <= 1'b0;
            pend_target          <= '0;
`ifdef FETCH_TIMEOUT_EN
            tmo_count            <= TMO_LOAD;
`endif
        end else begin
            ir_valid    <= 1'b0;
            fetch_fault <= 1'b0;
            case (state)
                IDLE: begin
                    pend_valid <= 1'b0;
                    if (fetch_start) begin
                        mem_addr        <= idle_fetch_addr;
                        program_counter <= idle_fetch_addr;
                        mem_req         <= 1'b1;
                        busy            <= 1'b1;
                        state           <= REQ;
`ifdef FETCH_TIMEOUT_EN
                        tmo_count       <= TMO_LOAD;
`endif
                    end else if (pc_load) begin
                        program_counter <= pc_load_value;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        instruction_register <= mem_rdata;
                        ir_valid             <= 1'b1;
                        mem_req              <= 1'b0;
                        busy                 <= 1'b0;
                        pend_valid           <= 1'b0;
                        program_counter      <= jump_sel ? jump_addr
                                                         : mem_addr + ADDR_WIDTH'(1);
                        state                <= IDLE;
`ifdef FETCH_TIMEOUT_EN
                    end else if (tmo_count == '0) begin
                        // Watchdog expiry: no increment, IR back to the idle opcode.
                        instruction_register <= IR_INIT;
                        fetch_fault          <= 1'b1;
                        mem_req              <= 1'b0;
                        busy                 <= 1'b0;
                        pend_valid           <= 1'b0;
                        program_counter      <= jump_sel ? jump_addr : mem_addr;
                        state                <= IDLE;
                    end else begin
                        tmo_count <= tmo_count - CW'(1);
                        if (pc_load) begin
                            pend_valid  <= 1'b1;
                            pend_target <= pc_load_value;
                        end
`else
                    end else if (pc_load) begin
                        pend_valid  <= 1'b1;
                        pend_target <= pc_load_value;
`endif
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifndef FETCH_TIMEOUT_EN
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; memory is driven by hand from each scenario task.
module tb_instruction_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_start;
    logic        pc_load;
    logic [7:0]  pc_load_value;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] instruction_register;
    logic [7:0]  program_counter;
    logic        ir_valid;
    logic        busy;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    instruction_fetch_unit dut (
        .clock                (clock),
        .reset                (reset),
        .fetch_start          (fetch_start),
        .pc_load              (pc_load),
        .pc_load_value        (pc_load_value),
        .mem_req              (mem_req),
        .mem_addr             (mem_addr),
        .mem_rdata            (mem_rdata),
        .mem_ack              (mem_ack),
        .instruction_register (instruction_register),
        .program_counter      (program_counter),
        .ir_valid             (ir_valid),
        .busy                 (busy),
        .fetch_fault          (fetch_fault)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; fetch_start = 1'b0; pc_load = 1'b0; pc_load_value = 8'h00;
        mem_rdata = 16'h0000; mem_ack = 1'b0;
        step(); step();
        reset = 1'b0;
        checks++; if (program_counter !== 8'h00) begin errors++; $display("FAIL reset_pc got %h want 00", program_counter); end
        checks++; if (instruction_register !== 16'hFF00) begin errors++; $display("FAIL reset_ir got %h want FF00", instruction_register); end
        checks++; if ({mem_req, ir_valid, busy, fetch_fault} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", {mem_req, ir_valid, busy, fetch_fault}); end
        checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", mem_addr); end
    endtask

    task automatic test_basic_fetch();
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        checks++; if ({mem_req, busy} !== 2'b11 || mem_addr !== 8'h00) begin errors++; $display("FAIL basic_req got req/busy %b addr %h want 11 00", {mem_req, busy}, mem_addr); end
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", ir_valid); end
        mem_ack = 1'b1; mem_rdata = 16'h0203;
        step();
        mem_ack = 1'b0;
        checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", ir_valid); end
        checks++; if (instruction_register !== 16'h0203) begin errors++; $display("FAIL basic_ir got %h want 0203", instruction_register); end
        checks++; if (program_counter !== 8'h01) begin errors++; $display("FAIL basic_pc got %h want 01", program_counter); end
        checks++; if ({mem_req, busy} !== 2'b00) begin errors++; $display("FAIL basic_done got req/busy %b want 00", {mem_req, busy}); end
        step();
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse got %b want 0", ir_valid); end
    endtask

    task automatic test_wrap();
        pc_load = 1'b1; pc_load_value = 8'hFF;
        step();
        pc_load = 1'b0;
        checks++; if (program_counter !== 8'hFF) begin errors++; $display("FAIL load_idle_pc got %h want FF", program_counter); end
        checks++; if ({mem_req, busy} !== 2'b00) begin errors++; $display("FAIL load_no_fetch got req/busy %b want 00", {mem_req, busy}); end
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        checks++; if (mem_addr !== 8'hFF) begin errors++; $display("FAIL wrap_addr got %h want FF", mem_addr); end
        mem_ack = 1'b1; mem_rdata = 16'h0000;
        step();
        mem_ack = 1'b0;
        checks++; if (program_counter !== 8'h00) begin errors++; $display("FAIL wrap_pc got %h want 00", program_counter); end
        checks++; if (instruction_register !== 16'h0000) begin errors++; $display("FAIL wrap_ir got %h want 0000", instruction_register); end
    endtask

    task automatic test_start_with_load();
        fetch_start = 1'b1; pc_load = 1'b1; pc_load_value = 8'h40;
        step();
        fetch_start = 1'b0; pc_load = 1'b0;
        checks++; if (mem_addr !== 8'h40 || mem_req !== 1'b1) begin errors++; $display("FAIL jump_start_addr got %h req %b want 40 1", mem_addr, mem_req); end
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        step();
        mem_ack = 1'b0;
        checks++; if (program_counter !== 8'h41) begin errors++; $display("FAIL jump_start_pc got %h want 41", program_counter); end
        checks++; if (instruction_register !== 16'h1234) begin errors++; $display("FAIL jump_start_ir got %h want 1234", instruction_register); end
    endtask

    task automatic test_pending_jump();
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b1; pc_load = 1'b1; pc_load_value = 8'h20;
        step();
        fetch_start = 1'b0; pc_load = 1'b0;
        step(); step();
        checks++; if (mem_addr !== 8'h41 || mem_req !== 1'b1) begin errors++; $display("FAIL pend_hold got addr %h req %b want 41 1", mem_addr, mem_req); end
        mem_ack = 1'b1; mem_rdata = 16'h5678;
        step();
        mem_ack = 1'b0;
        checks++; if (program_counter !== 8'h20) begin errors++; $display("FAIL pend_pc got %h want 20", program_counter); end
        checks++; if (instruction_register !== 16'h5678) begin errors++; $display("FAIL pend_ir got %h want 5678", instruction_register); end
        step();
        checks++; if ({mem_req, busy} !== 2'b00) begin errors++; $display("FAIL req_start_ignored got req/busy %b want 00", {mem_req, busy}); end
        mem_ack = 1'b1; mem_rdata = 16'hAAAA;
        step();
        mem_ack = 1'b0;
        checks++; if (instruction_register !== 16'h5678 || ir_valid !== 1'b0) begin errors++; $display("FAIL idle_ack_ignored got %h valid %b want 5678 0", instruction_register, ir_valid); end
    endtask

    task automatic test_ack_cycle_load();
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0; pc_load = 1'b1; pc_load_value = 8'h30;
        step();
        pc_load = 1'b1; pc_load_value = 8'h50; mem_ack = 1'b1; mem_rdata = 16'h9ABC;
        step();
        pc_load = 1'b0; mem_ack = 1'b0;
        checks++; if (program_counter !== 8'h50) begin errors++; $display("FAIL ack_load_pc got %h want 50", program_counter); end
    endtask

    task automatic test_back_to_back();
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h1111;
        step();
        mem_ack = 1'b0; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h51) begin errors++; $display("FAIL b2b_second got req %b addr %h want 1 51", mem_req, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 16'h2222;
        step();
        mem_ack = 1'b0;
        checks++; if (instruction_register !== 16'h2222 || program_counter !== 8'h52 || ir_valid !== 1'b1) begin errors++; $display("FAIL b2b_done got ir %h pc %h valid %b want 2222 52 1", instruction_register, program_counter, ir_valid); end
    endtask

    task automatic test_reset_mid_fetch();
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if ({mem_req, busy} !== 2'b00 || program_counter !== 8'h00 || instruction_register !== 16'hFF00) begin errors++; $display("FAIL mid_reset got req/busy %b pc %h ir %h want 00 00 FF00", {mem_req, busy}, program_counter, instruction_register); end
        mem_ack = 1'b1; mem_rdata = 16'h3333;
        step();
        mem_ack = 1'b0;
        checks++; if (instruction_register !== 16'hFF00 || ir_valid !== 1'b0) begin errors++; $display("FAIL late_ack got ir %h valid %b want FF00 0", instruction_register, ir_valid); end
    endtask

    task automatic test_timeout();
        logic held;
        pc_load = 1'b1; pc_load_value = 8'h10;
        step();
        pc_load = 1'b0; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        held = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step();
            if (mem_req !== 1'b1 || fetch_fault !== 1'b0) held = 1'b0;
        end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL tmo_early got held %b want 1", held); end
        step();
        checks++; if (fetch_fault !== 1'b1 || ir_valid !== 1'b0) begin errors++; $display("FAIL tmo_fault got fault %b valid %b want 1 0", fetch_fault, ir_valid); end
        checks++; if (instruction_register !== 16'hFF00 || program_counter !== 8'h10 || busy !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL tmo_state got ir %h pc %h busy %b req %b want FF00 10 0 0", instruction_register, program_counter, busy, mem_req); end
        step();
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL tmo_pulse got %b want 0", fetch_fault); end
`else
        held = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (mem_req !== 1'b1 || busy !== 1'b1 || fetch_fault !== 1'b0 || mem_addr !== 8'h10) held = 1'b0;
        end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL wait_hold got held %b want 1", held); end
        mem_ack = 1'b1; mem_rdata = 16'h4444;
        step();
        mem_ack = 1'b0;
        checks++; if (instruction_register !== 16'h4444 || program_counter !== 8'h11 || ir_valid !== 1'b1) begin errors++; $display("FAIL wait_done got ir %h pc %h valid %b want 4444 11 1", instruction_register, program_counter, ir_valid); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_wrap();
        test_start_with_load();
        test_pending_jump();
        test_ack_cycle_load();
        test_back_to_back();
        test_reset_mid_fetch();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
